// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath.
// Moore sequencing of each instruction plus opcode/funct decode into ALU controls.
module mips_multicycle_controller #(
  parameter int unsigned OPCODE_WIDTH = 6,
  parameter int unsigned FUNCT_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [FUNCT_WIDTH-1:0]  funct,
  input  logic                    zero,
  output logic                    iord,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic                    reg_dst,
  output logic                    mem_to_reg,
  output logic                    reg_write,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              pc_src,
  output logic [2:0]              alu_control,
  output logic                    pc_en,
  output logic                    illegal_op,
  output logic [3:0]              state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'b001000);
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'b000010);

  localparam logic [FUNCT_WIDTH-1:0] FN_ADD = FUNCT_WIDTH'(6'b100000);
  localparam logic [FUNCT_WIDTH-1:0] FN_SUB = FUNCT_WIDTH'(6'b100010);
  localparam logic [FUNCT_WIDTH-1:0] FN_AND = FUNCT_WIDTH'(6'b100100);
  localparam logic [FUNCT_WIDTH-1:0] FN_OR  = FUNCT_WIDTH'(6'b100101);
  localparam logic [FUNCT_WIDTH-1:0] FN_SLT = FUNCT_WIDTH'(6'b101010);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  state_t     state_q;
  state_t     state_d;
  logic       pc_write;
  logic       branch;
  logic [2:0] funct_alu;
  logic       funct_ok;

  // State register; reset lands in FETCH without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // R-type funct to ALU operation.
  always_comb begin
    funct_alu = ALU_ADD;
    funct_ok  = 1'b1;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // Next state and Moore outputs; write enables are masked while in reset.
  always_comb begin
    state_d     = S_FETCH;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    pc_src      = PCSRC_ALU;
    alu_control = ALU_ADD;
    pc_write    = 1'b0;
    branch      = 1'b0;
    illegal_op  = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
        illegal_op  = ~funct_ok;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = PCSRC_ALUOUT;
        branch      = 1'b1;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    pc_en = pc_write | (branch & zero);

    if (rst) begin
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      pc_en      = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign state = 4'(state_q);

endmodule
